count_uart_tx: RTL and testbench

- Serial transmitter for the 8-bit counter value: an 8N1 UART (optional even parity) that sends the count off-chip on a single uio pin.
- Sits beside the counter core inside the top-level user project, so a host can read the count back over one wire.
- Frames are launched by an explicit start request, or automatically whenever the input value differs from the last value sent.

---
 rtl/count_uart_tx.sv | 129 ++++++++++++
 tb/tb_count_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_tx.sv
// count_uart_tx: 8N1 UART transmitter (optional even parity) for the counter value.
// A frame is launched by an explicit start request. In auto mode, a frame is also
// launched whenever data_in differs from the last value sent.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        design enable; gates launching of new frames only
//   data_in    8-bit value to transmit
//   start      transmit request, honoured only in IDLE
//   auto_mode  when 1, launch a frame whenever data_in != last value sent
//   tx         serial line, idle high (registered)
//   busy       high while a frame is in progress (registered)
//   frame_done single-cycle pulse when a frame completes (registered)
//   overrun    sticky: start requested while busy, cleared only by reset (registered)
module count_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       start,
    input  logic       auto_mode,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      data_q;     // frozen copy of the byte in flight
    logic [7:0]      last_sent;

    logic            trigger_c;
    logic            bit_end_c;

    // A start request and an auto-mode difference in the same cycle merge into one frame.
    assign trigger_c = ena & (start | (auto_mode & (data_in != last_sent)));
    assign bit_end_c = (timer == T_LAST);

    // Frame sequencer; every output is driven from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_idx    <= 3'd0;
            data_q     <= 8'h00;
            last_sent  <= 8'h00;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // The request itself is dropped; only the flag records it.
            if (start && busy) begin
                overrun <= 1'b1;
            end

            if (state == S_IDLE) begin
                timer <= '0;
                if (trigger_c) begin
                    data_q    <= data_in;
                    last_sent <= data_in;
                    state     <= S_START;
                    tx        <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (!bit_end_c) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        tx      <= data_q[0];
                    end
                    S_DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                state <= S_PARITY;
                                tx    <= ^data_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= data_q[bit_idx + 3'd1];
                        end
                    end
                    S_PARITY: begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                    S_STOP: begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        tx         <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: bench for count_uart_tx.
// Two instances share all inputs: one without parity and one with even parity.
// A frame-level reference model predicts launched bytes and busy/frame_done/overrun.
// A line receiver decodes tx and checks each frame against the expected-byte queue.
module tb_count_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] data_in;
    logic       start;
    logic       auto_mode;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] frame_done;
    logic [1:0] overrun;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    count_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .start(start),
        .auto_mode(auto_mode), .tx(tx[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .overrun(overrun[0])
    );

    count_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .start(start),
        .auto_mode(auto_mode), .tx(tx[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .overrun(overrun[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_chk
        localparam int unsigned NB    = 10 + g;      // bits per frame
        localparam int unsigned FRAME = NB * CPB;    // cycles per frame

        int         remaining;
        logic       exp_ovr;
        logic       exp_done;
        logic [7:0] last;
        logic [7:0] q[$];

        logic        wave [0:11*CPB-1];
        int          rx_cnt;
        bit          rx_on;
        logic [10:0] obs;
        logic [10:0] expw;
        logic [7:0]  d;
        bit          stable;

        // Reference model: a frame occupies FRAME cycles; a new one may start once it is over.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                remaining = 0;
                exp_ovr   = 1'b0;
                exp_done  = 1'b0;
                last      = 8'h00;
                q.delete();
            end else begin
                exp_done = (remaining == 1);
                if (remaining > 0) begin
                    if (start) exp_ovr = 1'b1;
                    remaining--;
                end else if (ena && (start || (auto_mode && data_in != last))) begin
                    last = data_in;
                    q.push_back(data_in);
                    remaining = FRAME;
                end
            end
        end

        // Per-cycle status checks against the model.
        always @(negedge clk) begin
            if (rst_n && chk_en) begin
                check($sformatf("busy%0d", g), busy[g], (remaining > 0) ? 1 : 0);
                check($sformatf("frame_done%0d", g), frame_done[g], exp_done);
                check($sformatf("overrun%0d", g), overrun[g], exp_ovr);
                if (remaining == 0) check($sformatf("tx_idle%0d", g), tx[g], 1);
            end
        end

        // Line receiver: capture one sample per cycle for a whole frame, then compare.
        always @(negedge clk) begin
            if (!rst_n) begin
                rx_on  = 1'b0;
                rx_cnt = 0;
            end else if (!rx_on) begin
                if (tx[g] == 1'b0) begin
                    rx_on   = 1'b1;
                    wave[0] = 1'b0;
                    rx_cnt  = 1;
                end
            end else begin
                wave[rx_cnt] = tx[g];
                rx_cnt++;
                if (rx_cnt == FRAME) begin
                    rx_on  = 1'b0;
                    obs    = '0;
                    stable = 1'b1;
                    for (int k = 0; k < NB; k++) begin
                        obs[k] = wave[k*CPB];
                        for (int j = 1; j < CPB; j++)
                            if (wave[k*CPB+j] !== wave[k*CPB]) stable = 1'b0;
                    end
                    check($sformatf("frame_expected%0d", g), (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        d          = q.pop_front();
                        expw       = '0;
                        expw[0]    = 1'b0;
                        expw[8:1]  = d;
                        if (g == 1) expw[9] = ^d;
                        expw[NB-1] = 1'b1;
                        check($sformatf("frame_bits%0d", g), obs, expw);
                        check($sformatf("bit_hold%0d", g), stable, 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        ena       = 1'b0;
        data_in   = 8'h00;
        start     = 1'b0;
        auto_mode = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        // Reset values appear without any clock edge.
        for (int i = 0; i < 2; i++) begin
            check("reset_tx", tx[i], 1);
            check("reset_busy", busy[i], 0);
            check("reset_frame_done", frame_done[i], 0);
            check("reset_overrun", overrun[i], 0);
        end
        cyc(3);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cyc(2);

        // Single frame 0xA5 on both instances.
        ena = 1'b1; data_in = 8'hA5; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(60);

        // 0x07: parity bit is 1 on the parity instance.
        data_in = 8'h07; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(60);

        // Auto mode from a clean last_sent of 0x00.
        do_reset();
        auto_mode = 1'b1; data_in = 8'h00;
        cyc(100);
        data_in = 8'h01;
        cyc(10);
        data_in = 8'h02;
        cyc(140);
        auto_mode = 1'b0;

        // Start mid-frame sets the sticky overrun flag.
        data_in = 8'h3C; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(10);
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(80);

        // Asynchronous reset during data bit 3 aborts the frame.
        data_in = 8'hC3; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(17);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("abort_tx", tx[i], 1);
            check("abort_busy", busy[i], 0);
            check("abort_overrun", overrun[i], 0);
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(60);

        // ena gating, then ena dropped mid-frame.
        ena = 1'b0; data_in = 8'h5A; start = 1'b1;
        cyc(20);
        ena = 1'b1;
        cyc(1); start = 1'b0;
        cyc(10);
        ena = 1'b0;
        cyc(60);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ena   = ($urandom % 8) != 0;
            start = ($urandom % 24) == 0;
            if (($urandom % 100) == 0) auto_mode = $urandom % 2;
            if (($urandom % 25) == 0) data_in = 8'($urandom);
            cyc(1);
        end
        start = 1'b0; auto_mode = 1'b0;
        cyc(120);

        check("pending0", g_chk[0].q.size(), 0);
        check("pending1", g_chk[1].q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
